// File: rtl/hazard_stall_if.sv
// Hazard controller bundle: ID operands, per-stage dest/enable, branch in;
// load enables, bubbles, flush, freeze, forward selects and perf counters out.
interface hazard_stall_if #(
  parameter int NUM_SRC = 3,
  parameter int RA_W    = 4
);
  logic [NUM_SRC*RA_W-1:0] id_src;
  logic [NUM_SRC-1:0]      id_src_used;
  logic [RA_W-1:0]         ex_rd;
  logic [RA_W-1:0]         mem_rd;
  logic [RA_W-1:0]         wb_rd;
  logic                    ex_rf_en;
  logic                    mem_rf_en;
  logic                    wb_rf_en;
  logic                    ex_load;
  logic                    mem_load;
  logic                    branch_taken;
  logic [NUM_SRC*2-1:0]    fwd_sel;
  logic                    pc_le;
  logic                    ifid_le;
  logic                    idex_le;
  logic                    exmem_le;
  logic                    idex_nop;
  logic                    memwb_nop;
  logic                    ifid_flush;
  logic                    freeze;
  logic [15:0]             stall_cnt;
  logic [15:0]             flush_cnt;

  modport master (
    output id_src, id_src_used,
    output ex_rd, mem_rd, wb_rd,
    output ex_rf_en, mem_rf_en, wb_rf_en,
    output ex_load, mem_load, branch_taken,
    input  fwd_sel, pc_le, ifid_le,
    input  idex_le, exmem_le, idex_nop,
    input  memwb_nop, ifid_flush, freeze,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src, id_src_used,
    input  ex_rd, mem_rd, wb_rd,
    input  ex_rf_en, mem_rf_en, wb_rf_en,
    input  ex_load, mem_load, branch_taken,
    output fwd_sel, pc_le, ifid_le,
    output idex_le, exmem_le, idex_nop,
    output memwb_nop, ifid_flush, freeze,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/forward/stall controller with multi-cycle load freeze FSM.
// Ports: CLK, CLR (async active-low), bus (hazard_stall_if.slave).
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int NUM_SRC  = 3,
  parameter int RA_W     = 4,
  parameter int LOAD_LAT = 1,
  parameter int PC_REG   = 15
) (
  input logic          CLK,
  input logic          CLR,
  hazard_stall_if.slave bus
);
  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [RA_W-1:0] PC_A = RA_W'(PC_REG);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_wcnt;
  logic [CW-1:0]        w_next_wcnt;
  logic                 w_use;
  logic [NUM_SRC*2-1:0] w_fwd;
  logic                 w_pc_le;
  logic                 w_be_le;
  logic                 w_idex_nop;
  logic                 w_memwb_nop;
  logic                 w_freeze;
  logic                 w_flush;
  logic                 w_unused_mem_load;

  // MEM/WB results are always forwardable; MEM_WAIT already holds ID.
  assign w_unused_mem_load = bus.mem_load;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_wcnt  <= w_next_wcnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_wcnt  = r_wcnt;
    unique case (r_state)
      RUN: begin
        if (bus.ex_load && (LOAD_LAT > 1)) begin
          w_next_state = MEM_WAIT;
          w_next_wcnt  = CW'(LOAD_LAT - 1);
        end
      end
      MEM_WAIT: begin
        w_next_wcnt = r_wcnt - CW'(1);
        if (r_wcnt == CW'(1))
          w_next_state = RUN;
      end
    endcase
  end

  // Per-operand match; a load in EX yields a stall, never an EX forward.
  always_comb begin
    w_use = 1'b0;
    w_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_used[i] &&
          bus.id_src[i*RA_W +: RA_W] != PC_A) begin
        if (bus.id_src[i*RA_W +: RA_W] == bus.ex_rd &&
            bus.ex_rf_en && bus.ex_load)
          w_use = 1'b1;
        if (bus.id_src[i*RA_W +: RA_W] == bus.ex_rd &&
            bus.ex_rf_en && !bus.ex_load)
          w_fwd[2*i +: 2] = 2'b01;
        else if (bus.id_src[i*RA_W +: RA_W] == bus.mem_rd &&
                 bus.mem_rf_en)
          w_fwd[2*i +: 2] = 2'b10;
        else if (bus.id_src[i*RA_W +: RA_W] == bus.wb_rd &&
                 bus.wb_rf_en)
          w_fwd[2*i +: 2] = 2'b11;
      end
    end
  end

  // Reset forces the quiescent output set regardless of inputs.
  always_comb begin
    w_pc_le     = 1'b1;
    w_be_le     = 1'b1;
    w_idex_nop  = 1'b0;
    w_memwb_nop = 1'b0;
    w_freeze    = 1'b0;
    if (!CLR) begin
      w_pc_le = 1'b1;
    end else if (r_state == MEM_WAIT) begin
      w_pc_le     = 1'b0;
      w_be_le     = 1'b0;
      w_memwb_nop = 1'b1;
      w_freeze    = 1'b1;
    end else begin
      w_pc_le    = ~w_use;
      w_idex_nop = w_use;
    end
    w_flush = CLR & bus.branch_taken & w_pc_le;
  end

  assign bus.fwd_sel    = CLR ? w_fwd : '0;
  assign bus.pc_le      = w_pc_le;
  assign bus.ifid_le    = w_pc_le;
  assign bus.idex_le    = w_be_le;
  assign bus.exmem_le   = w_be_le;
  assign bus.idex_nop   = w_idex_nop;
  assign bus.memwb_nop  = w_memwb_nop;
  assign bus.ifid_flush = w_flush;
  assign bus.freeze     = w_freeze;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_le && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = 16'h0000;
  assign bus.flush_cnt = 16'h0000;
`endif
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised hazard, forwarding and stall controller for the 5-stage ARM pipeline. It replaces the fixed 3-operand combinational hazard unit. It adds a configurable operand count and a multi-cycle data-memory wait state machine that freezes the whole pipeline while a load occupies MEM. It also gates branch flushes against freezes. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their load enables, NOP inserts, the PC enable and the ID operand muxes.

## Interface
- NUM_SRC, 3, number of ID source operands checked (Rn, Rm, Rd-as-store-data).
- RA_W, 4, register address width.
- LOAD_LAT, 1, data-memory cycles per load (1..8); 1 means single-cycle memory and no freeze.
- PC_REG, 15, register address never forwarded or hazard-checked.
- CLK  in  1  clock, rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- id_src  in  NUM_SRC*RA_W  ID source addresses; operand i occupies bits [i*RA_W +: RA_W].
- id_src_used  in  NUM_SRC  operand i is actually read.
- ex_rd, mem_rd, wb_rd  in  RA_W each  destination register per stage.
- ex_rf_en, mem_rf_en, wb_rf_en  in  1 each  register write enable per stage.
- ex_load  in  1  instruction in EX is a load.
- mem_load  in  1  instruction in MEM is a load.
- branch_taken  in  1  taken branch resolved in ID.
- fwd_sel  out  NUM_SRC*2  per-operand mux select: 00 regfile, 01 EX ALU, 10 MEM result, 11 WB.
- pc_le, ifid_le, idex_le, exmem_le  out  1 each  register load enables.
- idex_nop, memwb_nop  out  1 each  insert bubble into ID/EX or MEM/WB.
- ifid_flush  out  1  clear IF/ID.
- freeze  out  1  MEM_WAIT active.
- stall_cnt, flush_cnt  out  16 each  performance counters (see Configuration).

## Operation
- FSM states:
  - RUN (reset state).
  - MEM_WAIT, with down-counter wcnt of width $clog2(LOAD_LAT+1), reset to 0.
- Transition RUN→MEM_WAIT: on a CLK edge in RUN with ex_load=1 and LOAD_LAT>1. wcnt loads LOAD_LAT-1.
- In MEM_WAIT: wcnt decrements each edge. At the edge where wcnt==1, the FSM returns to RUN.
- Load-use hazard (use): RUN, ex_load & ex_rf_en, and some i has id_src_used[i] with id_src[i]==ex_rd and id_src[i]!=PC_REG.
- Outputs in RUN:
  - pc_le = ifid_le = ~use.
  - idex_nop = use.
  - idex_le = exmem_le = 1.
  - memwb_nop = 0.
- Outputs in MEM_WAIT:
  - pc_le = ifid_le = idex_le = exmem_le = 0.
  - memwb_nop = 1, idex_nop = 0, freeze = 1.
- Forwarding, per operand, applies only when used and the address is not PC_REG. Priority, highest first:
  - 01 when id_src==ex_rd & ex_rf_en & ~ex_load.
  - 10 when id_src==mem_rd & mem_rf_en.
  - 11 when id_src==wb_rd & wb_rf_en.
  - Otherwise 00.
- The ex_load match produces a stall, never 01.
- MEM data is valid only in RUN. Forwarding from a mem_load stage is legal because MEM_WAIT already blocks ID.
- ifid_flush = branch_taken & pc_le. A branch blocked by a stall or freeze stays in ID and re-resolves.
- When use and branch_taken are both high, the stall wins and there is no flush.

## Timing
- All stall and forward outputs are combinational from inputs and state.
- The FSM and counters update on the CLK rising edge.
- CLR low asynchronously forces:
  - state RUN, wcnt 0, counters 0.
  - Outputs: pc_le = ifid_le = idex_le = exmem_le = 1, all NOP and flush outputs 0, freeze 0, fwd_sel all 00 (inputs deasserted).
- A freeze lasts exactly LOAD_LAT-1 cycles per load entering MEM. The load's data is forwardable in the following RUN cycle.
- Load-use costs 1 bubble plus LOAD_LAT-1 freeze cycles.
- CLR asserted during MEM_WAIT aborts the freeze immediately. There is no resume.
- Back-to-back loads each trigger their own MEM_WAIT. A load sitting in EX during a freeze is held; it triggers its own MEM_WAIT only after RUN resumes.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on each cycle where pc_le==0.
  - flush_cnt increments on each cycle where ifid_flush==1.
  - Both saturate at 16'hFFFF and clear on reset.
- HAZARD_PERF_CNT_EN undefined: no counter registers; both ports are tied to 16'h0000.

## Test plan
- Reset: CLR=0 with ex_load=1 and branch_taken=1 → pc_le=1, ifid_flush=0, freeze=0, fwd_sel=0.
- Forward priority, LOAD_LAT=1: id_src[0]=R3; ex_rd=mem_rd=wb_rd=3, all rf_en=1, ex_load=0 → fwd_sel[1:0]=01. Drop ex_rf_en → 10. Also drop mem_rf_en → 11.
- Load-use, LOAD_LAT=1: ex_load=1, ex_rd=2, id_src[1]=2 used → one cycle with pc_le=0 and idex_nop=1. Next cycle, with mem_rd=2 and mem_load=1 → fwd_sel[3:2]=10.
- Freeze, LOAD_LAT=4: ex_load=1, no dependency → freeze=1 and memwb_nop=1 for exactly 3 cycles, then RUN.
- PC_REG exclusion: ex_load=1, ex_rd=15, id_src[0]=15 used → no stall, fwd_sel=00.
- Branch vs stall, with HAZARD_PERF_CNT_EN: branch_taken=1 during a 3-cycle freeze → ifid_flush=0 for 3 cycles, then 1. stall_cnt=3, flush_cnt=1.
